// File: rtl/fpu_mult_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fpu_mult_pkg                                                    |
// | Desc     : Shared widths, rounding-mode encodings and normalized-stage     |
// |            intermediate type for the FPU multiplier back end.              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package fpu_mult_pkg;

  localparam int SW_DEFAULT   = 24;
  localparam int EW_DEFAULT   = 8;
  localparam int BIAS_DEFAULT = 127;

  localparam logic [1:0] c_rnd_rne = 2'b00;
  localparam logic [1:0] c_rnd_rz  = 2'b01;
  localparam logic [1:0] c_rnd_rup = 2'b10;
  localparam logic [1:0] c_rnd_rdn = 2'b11;

  // Field widths follow the package defaults; the datapath instantiates
  // with matching SW/EW.
  typedef struct packed {
    logic [SW_DEFAULT-1:0] m;
    logic                  guard;
    logic                  sticky;
    logic [EW_DEFAULT+1:0] e;
    logic                  sign;
    logic                  zero;
    logic [1:0]            rnd;
  } norm_t;

  // Directed modes that round toward zero for this sign clamp to max finite.
  function automatic logic sat_on_ovf(input logic [1:0] mode, input logic sign);
    return (mode == c_rnd_rz) ||
           ((mode == c_rnd_rup) && sign) ||
           ((mode == c_rnd_rdn) && !sign);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_round_inc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mult_round_inc                                                  |
// | Desc     : Rounding increment decode, significand increment and carry-out  |
// |            renormalization for the round stage.                            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mult_round_inc
  import fpu_mult_pkg::*;
#(
  parameter int SW = SW_DEFAULT
) (
  input  logic [SW-1:0] i_m,
  input  logic          i_guard,
  input  logic          i_sticky,
  input  logic          i_sign,
  input  logic [1:0]    i_rnd_mode,
  output logic [SW-1:0] o_mant,
  output logic          o_carry,
  output logic          o_inexact,
  output logic          o_sat
);

  logic        w_lost;
  logic        w_inc;
  logic [SW:0] w_sum;

  assign w_lost = i_guard | i_sticky;

  always_comb begin
    w_inc = 1'b0;
    case (i_rnd_mode)
      c_rnd_rne: w_inc = i_guard & (i_sticky | i_m[0]);
      c_rnd_rz:  w_inc = 1'b0;
      c_rnd_rup: w_inc = ~i_sign & w_lost;
      c_rnd_rdn: w_inc = i_sign & w_lost;
      default:   w_inc = 1'b0;
    endcase
  end

  assign w_sum   = {1'b0, i_m} + {{SW{1'b0}}, w_inc};
  assign o_carry = w_sum[SW];

  // A carry out only happens from all-ones, so the result is exactly 1.0.
  assign o_mant    = o_carry ? {1'b1, {(SW-1){1'b0}}} : w_sum[SW-1:0];
  assign o_inexact = w_lost;
  assign o_sat     = sat_on_ovf(i_rnd_mode, i_sign);

endmodule
`default_nettype wire

// File: rtl/mult_norm_round.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mult_norm_round                                                 |
// | Desc     : Two-stage valid/ready normalize + round stage for the mantissa  |
// |            product. Optional macro MULT_ROUND_MODES_EN adds rnd_mode_i.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mult_norm_round
  import fpu_mult_pkg::*;
#(
  parameter int SW = SW_DEFAULT,
  parameter int EW = EW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2*SW-1:0] Data_S_i,
  input  logic [EW+1:0]   Exp_i,
  input  logic            Sign_i,
`ifdef MULT_ROUND_MODES_EN
  input  logic [1:0]      rnd_mode_i,
`endif
  output logic            valid_o,
  input  logic            ready_i,
  output logic [SW-1:0]   Mant_o,
  output logic [EW-1:0]   Exp_o,
  output logic            Sign_o,
  output logic            Ovf_o,
  output logic            Unf_o,
  output logic            Inexact_o
);

  localparam logic signed [EW+1:0] c_exp_max = (EW+2)'((1 << EW) - 1);
  localparam logic        [EW-1:0] c_exp_sat = {{(EW-1){1'b1}}, 1'b0};

  // ---------------------------------------------------------------- handshake
  logic w_s1_ready;
  logic w_s2_ready;
  logic r_s1_valid;
  logic r_s2_valid;

  assign w_s2_ready = ~r_s2_valid | ready_i;
  assign w_s1_ready = ~r_s1_valid | w_s2_ready;
  assign ready_o    = w_s1_ready;

  // ---------------------------------------------------------------- normalize
  logic [1:0] w_rnd;
  logic       w_top;
  norm_t      w_n1;
  norm_t      r_s1;

`ifdef MULT_ROUND_MODES_EN
  assign w_rnd = rnd_mode_i;
`else
  assign w_rnd = c_rnd_rne;
`endif

  assign w_top = Data_S_i[2*SW-1];

  always_comb begin
    w_n1      = '0;
    w_n1.sign = Sign_i;
    w_n1.zero = (Data_S_i == '0);
    w_n1.rnd  = w_rnd;
    if (w_top) begin
      w_n1.m      = Data_S_i[2*SW-1:SW];
      w_n1.guard  = Data_S_i[SW-1];
      w_n1.sticky = |Data_S_i[SW-2:0];
      w_n1.e      = Exp_i + (EW+2)'(1);
    end else begin
      w_n1.m      = Data_S_i[2*SW-2:SW-1];
      w_n1.guard  = Data_S_i[SW-2];
      w_n1.sticky = |Data_S_i[SW-3:0];
      w_n1.e      = Exp_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_s1_ready) begin
      r_s1_valid <= valid_i;
      if (valid_i) begin
        r_s1 <= w_n1;
      end
    end
  end

  // ---------------------------------------------------------------- round
  logic [SW-1:0]        w_rmant;
  logic                 w_carry;
  logic                 w_rinx;
  logic                 w_sat;
  logic signed [EW+1:0] w_e2;

  mult_round_inc #(
    .SW (SW)
  ) u_round_inc (
    .i_m        (r_s1.m),
    .i_guard    (r_s1.guard),
    .i_sticky   (r_s1.sticky),
    .i_sign     (r_s1.sign),
    .i_rnd_mode (r_s1.rnd),
    .o_mant     (w_rmant),
    .o_carry    (w_carry),
    .o_inexact  (w_rinx),
    .o_sat      (w_sat)
  );

  assign w_e2 = r_s1.e + {{(EW+1){1'b0}}, w_carry};

  // ---------------------------------------------------------------- range check
  logic [SW-1:0] w_mant;
  logic [EW-1:0] w_exp;
  logic          w_ovf;
  logic          w_unf;
  logic          w_inx;

  always_comb begin
    w_mant = w_rmant;
    w_exp  = w_e2[EW-1:0];
    w_ovf  = 1'b0;
    w_unf  = 1'b0;
    w_inx  = w_rinx;
    if (r_s1.zero) begin
      w_mant = '0;
      w_exp  = '0;
      w_inx  = 1'b0;
    end else if (w_e2 >= c_exp_max) begin
      w_ovf = 1'b1;
      if (w_sat) begin
        w_exp  = c_exp_sat;
        w_mant = '1;
      end else begin
        w_exp  = '1;
        w_mant = '0;
      end
    end else if (w_e2[EW+1] || (w_e2 == '0)) begin
      // No subnormal output: anything at or below zero flushes.
      w_unf  = 1'b1;
      w_exp  = '0;
      w_mant = '0;
    end
  end

  logic [SW-1:0] r_mant;
  logic [EW-1:0] r_exp;
  logic          r_sign;
  logic          r_ovf;
  logic          r_unf;
  logic          r_inexact;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_mant     <= '0;
      r_exp      <= '0;
      r_sign     <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_inexact  <= 1'b0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_mant    <= w_mant;
        r_exp     <= w_exp;
        r_sign    <= r_s1.sign;
        r_ovf     <= w_ovf;
        r_unf     <= w_unf;
        r_inexact <= w_inx;
      end
    end
  end

  assign valid_o   = r_s2_valid;
  assign Mant_o    = r_mant;
  assign Exp_o     = r_exp;
  assign Sign_o    = r_sign;
  assign Ovf_o     = r_ovf;
  assign Unf_o     = r_unf;
  assign Inexact_o = r_inexact;

endmodule
`default_nettype wire

// File: tb/tb_mult_norm_round.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mult_norm_round                                              |
// | Desc     : Self-checking bench: directed corner cases plus randomized      |
// |            traffic scored against an arithmetic rounding model.           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_mult_norm_round;

  localparam int SW = 24;
  localparam int EW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            valid_i = 1'b0;
  logic            ready_o;
  logic [2*SW-1:0] Data_S_i = '0;
  logic [EW+1:0]   Exp_i = '0;
  logic            Sign_i = 1'b0;
  logic            valid_o;
  logic            ready_i = 1'b0;
  logic [SW-1:0]   Mant_o;
  logic [EW-1:0]   Exp_o;
  logic            Sign_o;
  logic            Ovf_o;
  logic            Unf_o;
  logic            Inexact_o;
`ifdef MULT_ROUND_MODES_EN
  logic [1:0]      rnd_mode = 2'b00;
`endif

  always #5 clk = ~clk;

  mult_norm_round #(.SW(SW), .EW(EW)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .Data_S_i  (Data_S_i),
    .Exp_i     (Exp_i),
    .Sign_i    (Sign_i),
`ifdef MULT_ROUND_MODES_EN
    .rnd_mode_i(rnd_mode),
`endif
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .Mant_o    (Mant_o),
    .Exp_o     (Exp_o),
    .Sign_o    (Sign_o),
    .Ovf_o     (Ovf_o),
    .Unf_o     (Unf_o),
    .Inexact_o (Inexact_o)
  );

  typedef struct packed {
    logic [SW-1:0] mant;
    logic [EW-1:0] exp;
    logic          sign;
    logic          ovf;
    logic          unf;
    logic          inx;
  } res_t;

  int   n_total = 0;
  int   n_pass  = 0;
  int   n_out   = 0;
  res_t q[$];
  bit   sb_en     = 1'b0;
  bit   hold_pend = 1'b0;
  res_t held;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic res_t cur_out();
    return {Mant_o, Exp_o, Sign_o, Ovf_o, Unf_o, Inexact_o};
  endfunction

  task automatic check_out(input string tag, input res_t e);
    check({tag, ".mant"}, 64'(Mant_o), 64'(e.mant));
    check({tag, ".exp"},  64'(Exp_o),  64'(e.exp));
    check({tag, ".sign"}, 64'(Sign_o), 64'(e.sign));
    check({tag, ".ovf"},  64'(Ovf_o),  64'(e.ovf));
    check({tag, ".unf"},  64'(Unf_o),  64'(e.unf));
    check({tag, ".inx"},  64'(Inexact_o), 64'(e.inx));
  endtask

  // Value-level model: scale to SW integer bits, round half to even on the
  // discarded remainder, then apply the exponent range.
  function automatic res_t model(input logic [2*SW-1:0] p, input logic [EW+1:0] ex, input logic s);
    res_t            r;
    longint unsigned qv, rem, half;
    int              e, sh;
    r = '0;
    r.sign = s;
    if (p == '0) return r;
    sh   = (p >= (64'd1 << (2*SW-1))) ? SW : SW-1;
    e    = int'($signed(ex)) + sh - (SW-1);
    qv   = 64'(p) >> sh;
    rem  = 64'(p) - (qv << sh);
    half = 64'd1 << (sh-1);
    if ((rem > half) || ((rem == half) && qv[0])) qv++;
    if (qv == (64'd1 << SW)) begin
      qv = qv >> 1;
      e++;
    end
    r.inx = (rem != 0);
    if (e >= (1 << EW) - 1) begin
      r.ovf = 1'b1;
      r.exp = '1;
    end else if (e <= 0) begin
      r.unf = 1'b1;
    end else begin
      r.mant = qv[SW-1:0];
      r.exp  = e[EW-1:0];
    end
    return r;
  endfunction

  function automatic logic [2*SW-1:0] rand_product();
    logic [SW-1:0]   a, b;
    logic [2*SW-1:0] p;
    int              k;
    k = $urandom_range(0, 15);
    a = {1'b1, 23'($urandom)};
    b = {1'b1, 23'($urandom)};
    p = {{SW{1'b0}}, a} * {{SW{1'b0}}, b};
    if (k == 0)      p = '0;
    else if (k == 1) p[SW-1:0] = {1'b1, {(SW-1){1'b0}}};
    else if (k == 2) p[SW-2:0] = {1'b1, {(SW-2){1'b0}}};
    else if (k == 3) begin
      p[2*SW-1]        = 1'b0;
      p[2*SW-2:SW-2]   = '1;
    end
    return p;
  endfunction

  // Scoreboard: sees at the negedge exactly what the next posedge will transfer.
  always @(negedge clk) begin
    if (sb_en && !rst) begin
      if (hold_pend) begin
        check("hold_valid", 64'(valid_o), 64'd1);
        if (valid_o) check("hold_data", 64'(cur_out()), 64'(held));
      end
      hold_pend = 1'b0;
      if (valid_o) begin
        if (q.size() == 0) check("spurious_out", 64'(valid_o), 64'd0);
        else if (ready_i) begin
          check_out("rand", q.pop_front());
          n_out++;
        end
        if (!ready_i) begin
          hold_pend = 1'b1;
          held      = cur_out();
        end
      end
      if (valid_i && ready_o) q.push_back(model(Data_S_i, Exp_i, Sign_i));
    end
  end

  task automatic directed(input string tag, input logic [2*SW-1:0] p, input logic [EW+1:0] ex,
                          input logic s, input res_t e);
    @(posedge clk); #1;
    valid_i  = 1'b1;
    Data_S_i = p;
    Exp_i    = ex;
    Sign_i   = s;
    ready_i  = 1'b1;
    check({tag, ".rdy"}, 64'(ready_o), 64'd1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    check({tag, ".lat1"}, 64'(valid_o), 64'd0);
    @(posedge clk); #1;
    check({tag, ".vld"}, 64'(valid_o), 64'd1);
    check_out(tag, e);
  endtask

  task automatic rand_phase(input int cycles);
    logic acc;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      acc = valid_i & ready_o;
      @(posedge clk); #1;
      if (!valid_i || acc) begin
        valid_i  = ($urandom_range(0, 3) != 0);
        Data_S_i = rand_product();
        Exp_i    = 10'($urandom_range(0, 330)) - 10'd20;
        Sign_i   = 1'($urandom);
      end
      ready_i = ($urandom_range(0, 2) != 0);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    while ((q.size() != 0) && (n < 50)) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #1;
    check({tag, ".drained"}, 64'(q.size()), 64'd0);
    check({tag, ".idle"}, 64'(valid_o), 64'd0);
  endtask

  task automatic push_in(input logic [2*SW-1:0] p);
    @(posedge clk); #1;
    valid_i  = 1'b1;
    Data_S_i = p;
    Exp_i    = 10'd127;
    Sign_i   = 1'($urandom);
  endtask

  initial begin
    int base;
    #3;
    check("rst.valid_o", 64'(valid_o), 64'd0);
    check("rst.out", 64'(cur_out()), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst.ready_o", 64'(ready_o), 64'd1);

    directed("carry_out", 48'h900000000000, 10'd127, 1'b0, {24'h900000, 8'd128, 1'b0, 3'b000});
    directed("tie_even",  48'h400000400000, 10'd127, 1'b0, {24'h800000, 8'd127, 1'b0, 3'b001});
    directed("tie_odd",   48'h400000C00000, 10'd127, 1'b1, {24'h800002, 8'd127, 1'b1, 3'b001});
    directed("rnd_carry", 48'h7FFFFFC00000, 10'd100, 1'b0, {24'h800000, 8'd101, 1'b0, 3'b001});
    directed("ovf",       48'h800000000000, 10'd254, 1'b1, {24'h000000, 8'hFF,  1'b1, 3'b100});
    directed("ovf_rnd",   48'h7FFFFFC00000, 10'd254, 1'b0, {24'h000000, 8'hFF,  1'b0, 3'b101});
    directed("max_exp",   48'h400000000000, 10'd254, 1'b0, {24'h800000, 8'd254, 1'b0, 3'b000});
    directed("min_exp",   48'h400000000000, 10'd1,   1'b1, {24'h800000, 8'd1,   1'b1, 3'b000});
    directed("unf",       48'h400000000000, 10'd0,   1'b0, {24'h000000, 8'd0,   1'b0, 3'b010});
    directed("unf_neg",   48'h600000000000, 10'h3FB, 1'b1, {24'h000000, 8'd0,   1'b1, 3'b010});
    directed("zero",      48'h000000000000, 10'd77,  1'b1, {24'h000000, 8'd0,   1'b1, 3'b000});
    @(posedge clk); #1;

    sb_en = 1'b1;
    rand_phase(600);
    drain("rand");

    // Backpressure: third input must be held off while both stages are full.
    ready_i = 1'b0;
    base = n_out;
    push_in(rand_product());
    check("bp.rdy0", 64'(ready_o), 64'd1);
    push_in(rand_product());
    check("bp.rdy1", 64'(ready_o), 64'd1);
    push_in(rand_product());
    check("bp.rdy2", 64'(ready_o), 64'd0);
    check("bp.valid", 64'(valid_o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp.stall", 64'(ready_o), 64'd0);
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    drain("bp");
    check("bp.count", 64'(n_out - base), 64'd3);

    // Asynchronous reset with both stages occupied.
    ready_i = 1'b0;
    push_in(rand_product());
    push_in(rand_product());
    @(posedge clk); #1;
    valid_i = 1'b0;
    check("mid.full", 64'(ready_o), 64'd0);
    #2;
    sb_en = 1'b0;
    rst   = 1'b1;
    #1;
    check("mid.async_valid", 64'(valid_o), 64'd0);
    check("mid.async_out", 64'(cur_out()), 64'd0);
    q.delete();
    hold_pend = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid.ready", 64'(ready_o), 64'd1);
    ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("mid.no_stale", 64'(valid_o), 64'd0);
    end

    sb_en = 1'b1;
    rand_phase(200);
    drain("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/mult_norm_round.md
Name: mult_norm_round

Overview:
Downstream stage of the registered SW x SW mantissa multiplier. It consumes the raw 2*SW-bit significand product, together with the pre-computed exponent and sign. It produces a normalized, rounded SW-bit significand (hidden bit included), the final biased exponent, and overflow/underflow/inexact flags. It is a two-stage valid/ready pipeline (normalize, then round) and feeds the FPU result packer.

Parameters:
SW, 24, significand width including hidden bit (product is 2*SW bits)
EW, 8, biased exponent width
BIAS, 127, exponent bias (reference value only; the bias is already applied to Exp_i)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
valid_i  in  1  input product valid
ready_o  out  1  block can accept input this cycle
Data_S_i  in  2*SW  unsigned significand product, value in [1,4) scaled by 2^(2SW-2)
Exp_i  in  EW+2  two's-complement biased exponent: EA+EB-BIAS
Sign_i  in  1  result sign (SA xor SB)
valid_o  out  1  output valid
ready_i  in  1  downstream accepts output
Mant_o  out  SW  rounded significand, hidden bit at MSB
Exp_o  out  EW  final biased exponent
Sign_o  out  1  result sign
Ovf_o  out  1  exponent overflow, result forced to infinity
Unf_o  out  1  exponent underflow, result flushed to zero
Inexact_o  out  1  guard or sticky was nonzero

Behaviour:
- Reset (async, rst=1): both stage valid bits = 0; all outputs = 0; ready_o = 1 once rst deasserts.
- Transfer rules: a transfer occurs on a cycle where valid&ready are both high. Once valid_o is asserted, outputs must hold steady until ready_i=1.
- Stage advance: a stage loads when it is empty or its content moves on in the same cycle.
- ready_o = !s1_valid | (!s2_valid | ready_i). This is combinational from ready_i; no skid buffer.
- Latency and throughput: 2 cycles from input transfer to valid_o with ready_i held high; throughput 1 per cycle.
- S1 (normalize), when P[2SW-1]=1:
  - m = P[2SW-1:SW]; guard = P[SW-1]; sticky = |P[SW-2:0]; e = Exp_i+1.
- S1 (normalize), otherwise:
  - m = P[2SW-2:SW-1]; guard = P[SW-2]; sticky = |P[SW-3:0]; e = Exp_i.
- S1 zero flag: zero = (P==0).
- S2 (round): default is round-to-nearest-even.
  - inc = guard & (sticky | m[0]).
  - mr = m+inc, computed SW+1 bits wide.
  - If mr[SW]=1: Mant = {1,0...0}, e = e+1.
  - Inexact = guard|sticky.
- S2 (range check), applied after rounding, in priority order:
  - zero → Mant_o=0, Exp_o=0, no flags.
  - e >= 2^EW-1 → Ovf_o=1, Exp_o=all ones, Mant_o=0.
  - e <= 0 → Unf_o=1, Exp_o=0, Mant_o=0; no subnormal output.
  - Otherwise Exp_o = e[EW-1:0].
- Sign_o always passes through, including for zero/inf results.
- Flags are valid only while valid_o=1. They are registered alongside the data.
- Simultaneous input accept and output drain: both stages shift in the same cycle with no bubble.

Optional Feature:
Macro: MULT_ROUND_MODES_EN.
- Defined:
  - Extra port rnd_mode_i, in, 2 bits, sampled with valid_i and carried through S1.
  - Encoding: 00 RNE, 01 toward zero (inc=0), 10 toward +inf (inc=!sign&(g|s)), 11 toward -inf (inc=sign&(g|s)).
  - Overflow under RZ, or under the directed mode away from the sign, saturates: Exp_o=2^EW-2, Mant_o=all ones, Ovf_o=1.
- Undefined: the port does not exist and RNE is hard-wired.

Decomposition:
- Shared package fpu_mult_pkg holds:
  - SW/EW/BIAS defaults.
  - The rounding-mode encoding constants.
  - A normalized-intermediate struct: m, guard, sticky, e, sign, zero.
- Sub-module mult_round_inc: the combinational increment, carry-out and mode decode, instantiated in S2.
- The handshake and staging registers live in the top.

Test Plan:
1. Carry-out path: Data_S_i=0x900000000000 (1.5*1.5), Exp_i=127, Sign_i=0 → after 2 cycles Mant_o=0x900000, Exp_o=128, all flags 0.
2. Ties to even: P=0x400000400000 (m LSB 0, guard 1, sticky 0) → Mant_o=0x800000, Inexact_o=1. P=0x400000C00000 → Mant_o=0x800002, Inexact_o=1.
3. Rounding carry: P=0x7FFFFFC00000, Exp_i=100 → Mant_o=0x800000, Exp_o=101, Inexact_o=1.
4. Range limits:
   - Exp_i=254 with P[47]=1 → Ovf_o=1, Exp_o=0xFF, Mant_o=0.
   - Exp_i=0 with P[47]=0 → Unf_o=1, Exp_o=0, Mant_o=0.
   - P=0 with any Exp_i → all-zero result, no flags.
5. Backpressure: issue 3 back-to-back inputs with ready_i=0 → ready_o falls after 2 accepts and the 3rd is held off. Release ready_i → outputs appear in order with stable values; none lost or duplicated.
6. Reset mid-operation: assert rst while both stages are valid → valid_o drops immediately (async). After release ready_o=1 and no stale result emerges.
